// File: rtl/pipe_demux_1to2.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes on every channel.
// One producer stream is steered per transfer to channel 0 or channel 1; each
// channel owns a single output register slot and a wrapping transfer counter.
// A full slot only stalls the producer when that slot is the selected one.

module pipe_demux_1to2 #(
   parameter int N  = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          in_sel,
   input  logic [N-1:0]  in_data,
   output logic          in_ready,
   output logic          out0_valid,
   output logic [N-1:0]  out0_data,
   input  logic          out0_ready,
   output logic          out1_valid,
   output logic [N-1:0]  out1_data,
   input  logic          out1_ready,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1
);

   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [N-1:0]  DATA_ZERO = {N{1'b0}};

   logic          out0_valid_r;
   logic [N-1:0]  out0_data_r;
   logic          out1_valid_r;
   logic [N-1:0]  out1_data_r;
   logic [CW-1:0] cnt0_r;
   logic [CW-1:0] cnt1_r;

   logic          in_ready_s;
   logic          in_fire_s;
   logic          load0_s;
   logic          load1_s;
   logic          out0_fire_s;
   logic          out1_fire_s;

   // Producer ready: only the selected slot's occupancy and drain decide it.
   always_comb begin
      in_ready_s = 1'b0;
      if (!rst_n || flush) begin
         in_ready_s = 1'b0;
      end else if (in_sel) begin
         in_ready_s = !out1_valid_r || out1_ready;
      end else begin
         in_ready_s = !out0_valid_r || out0_ready;
      end
   end

   // Handshake decode shared by the slot and counter registers.
   always_comb begin
      in_fire_s   = in_valid && in_ready_s;
      load0_s     = in_fire_s && !in_sel;
      load1_s     = in_fire_s && in_sel;
      out0_fire_s = out0_valid_r && out0_ready;
      out1_fire_s = out1_valid_r && out1_ready;
   end

   // Channel 0 slot: flush beats load, load beats drain, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out0_valid_r <= 1'b0;
         out0_data_r  <= DATA_ZERO;
      end else if (flush) begin
         out0_valid_r <= 1'b0;
         out0_data_r  <= out0_data_r;
      end else if (load0_s) begin
         out0_valid_r <= 1'b1;
         out0_data_r  <= in_data;
      end else if (out0_fire_s) begin
         out0_valid_r <= 1'b0;
         out0_data_r  <= out0_data_r;
      end else begin
         out0_valid_r <= out0_valid_r;
         out0_data_r  <= out0_data_r;
      end
   end

   // Channel 1 slot: same priority order as channel 0, fully independent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out1_valid_r <= 1'b0;
         out1_data_r  <= DATA_ZERO;
      end else if (flush) begin
         out1_valid_r <= 1'b0;
         out1_data_r  <= out1_data_r;
      end else if (load1_s) begin
         out1_valid_r <= 1'b1;
         out1_data_r  <= in_data;
      end else if (out1_fire_s) begin
         out1_valid_r <= 1'b0;
         out1_data_r  <= out1_data_r;
      end else begin
         out1_valid_r <= out1_valid_r;
         out1_data_r  <= out1_data_r;
      end
   end

   // Completed-handshake counters; a drain coinciding with flush still counts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0_r <= CNT_ZERO;
         cnt1_r <= CNT_ZERO;
      end else begin
         if (out0_fire_s) begin
            cnt0_r <= cnt0_r + CNT_ONE;
         end else begin
            cnt0_r <= cnt0_r;
         end
         if (out1_fire_s) begin
            cnt1_r <= cnt1_r + CNT_ONE;
         end else begin
            cnt1_r <= cnt1_r;
         end
      end
   end

   assign in_ready   = in_ready_s;
   assign out0_valid = out0_valid_r;
   assign out0_data  = out0_data_r;
   assign out1_valid = out1_valid_r;
   assign out1_data  = out1_data_r;
   assign cnt0       = cnt0_r;
   assign cnt1       = cnt1_r;

endmodule

// File: tb/tb_pipe_demux_1to2.sv
// Self-checking bench for pipe_demux_1to2: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the two slots and their counters.

module tb_pipe_demux_1to2;

   localparam int N  = 32;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_sel;
   logic [N-1:0]  in_data;
   logic          in_ready;
   logic          out0_valid;
   logic [N-1:0]  out0_data;
   logic          out0_ready;
   logic          out1_valid;
   logic [N-1:0]  out1_data;
   logic          out1_ready;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;

   int checks = 0;
   int errors = 0;

   pipe_demux_1to2 #(.N(N), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out0_valid (out0_valid),
      .out0_data  (out0_data),
      .out0_ready (out0_ready),
      .out1_valid (out1_valid),
      .out1_data  (out1_data),
      .out1_ready (out1_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: each channel holds at most one pending word,
   // the last word delivered to it, and a count of completed handoffs.
   int          occ  [2];
   logic [31:0] word [2];
   int          done [2];
   bit          m_ok = 1'b0;

   // Compare DUT against the model mid-cycle, then advance the model by one edge.
   always @(negedge clk) begin
      bit          exp_ready;
      bit          rdy [2];
      bit          fire [2];
      int          sel;
      rdy[0] = out0_ready;
      rdy[1] = out1_ready;
      sel    = in_sel ? 1 : 0;
      if (!rst_n || flush) exp_ready = 1'b0;
      else exp_ready = (occ[sel] == 0) || rdy[sel];
      if (m_ok) begin
         chk("in_ready",   {31'd0, in_ready},   {31'd0, exp_ready});
         chk("out0_valid", {31'd0, out0_valid}, (occ[0] != 0) ? 32'd1 : 32'd0);
         chk("out1_valid", {31'd0, out1_valid}, (occ[1] != 0) ? 32'd1 : 32'd0);
         chk("out0_data",  out0_data, word[0]);
         chk("out1_data",  out1_data, word[1]);
         chk("cnt0", {28'd0, cnt0}, done[0] % (1 << CW));
         chk("cnt1", {28'd0, cnt1}, done[1] % (1 << CW));
      end
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            occ[k] = 0; word[k] = 32'd0; done[k] = 0;
         end
         m_ok = 1'b1;
      end else if (m_ok) begin
         for (int k = 0; k < 2; k++) fire[k] = (occ[k] != 0) && rdy[k];
         for (int k = 0; k < 2; k++) begin
            if (fire[k]) done[k] = done[k] + 1;
            if (flush) occ[k] = 0;
            else if (in_valid && exp_ready && sel == k) begin
               occ[k] = 1; word[k] = in_data;
            end else if (fire[k]) occ[k] = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 32'd0;
      out0_ready = 1'b0; out1_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      tick(); tick();
      rst_n = 1'b1;
      #1;
      // Reset state and idle readiness for both selections
      chk("rst out0_valid", {31'd0, out0_valid}, 32'd0);
      chk("rst out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("rst cnt0", {28'd0, cnt0}, 32'd0);
      chk("rst cnt1", {28'd0, cnt1}, 32'd0);
      chk("rst ready sel0", {31'd0, in_ready}, 32'd1);
      in_sel = 1'b1; #1;
      chk("rst ready sel1", {31'd0, in_ready}, 32'd1);
      tick();

      // Back-to-back stream to channel 0
      out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11; #1;
      chk("s0 ready", {31'd0, in_ready}, 32'd1);
      tick(); in_data = 32'h22; #1;
      chk("s0 d11", out0_data, 32'h11);
      chk("s0 ready2", {31'd0, in_ready}, 32'd1);
      tick(); in_data = 32'h33; #1;
      chk("s0 d22", out0_data, 32'h22);
      tick(); in_valid = 1'b0; #1;
      chk("s0 d33", out0_data, 32'h33);
      chk("s0 v", {31'd0, out0_valid}, 32'd1);
      tick(); #1;
      chk("s0 cnt0", {28'd0, cnt0}, 32'd3);
      chk("s0 out1_valid", {31'd0, out1_valid}, 32'd0);
      out0_ready = 1'b0;

      // Backpressure on channel 1
      in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hA5A5A5A5;
      tick(); in_data = 32'hDEADBEEF; #1;
      chk("bp ready low", {31'd0, in_ready}, 32'd0);
      chk("bp hold", out1_data, 32'hA5A5A5A5);
      tick(); #1;
      chk("bp hold2", out1_data, 32'hA5A5A5A5);
      out1_ready = 1'b1; #1;
      chk("bp ready high", {31'd0, in_ready}, 32'd1);
      tick(); in_valid = 1'b0; out1_ready = 1'b0; #1;
      chk("bp new word", out1_data, 32'hDEADBEEF);
      chk("bp cnt1", {28'd0, cnt1}, 32'd1);

      // Channel 1 stalled must not block channel 0
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h5; #1;
      chk("xc ready", {31'd0, in_ready}, 32'd1);
      tick(); in_valid = 1'b0; #1;
      chk("xc out0", out0_data, 32'h5);
      chk("xc out1 held", out1_data, 32'hDEADBEEF);
      chk("xc out1 v", {31'd0, out1_valid}, 32'd1);

      // Flush both full slots
      flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h77; #1;
      chk("fl ready", {31'd0, in_ready}, 32'd0);
      tick(); flush = 1'b0; in_valid = 1'b0; #1;
      chk("fl v0", {31'd0, out0_valid}, 32'd0);
      chk("fl v1", {31'd0, out1_valid}, 32'd0);
      chk("fl d0 kept", out0_data, 32'h5);
      chk("fl cnt0", {28'd0, cnt0}, 32'd3);
      chk("fl cnt1", {28'd0, cnt1}, 32'd1);
      in_valid = 1'b1; in_data = 32'h66;
      tick(); in_valid = 1'b0; flush = 1'b1; out0_ready = 1'b1;
      tick(); flush = 1'b0; out0_ready = 1'b0; #1;
      chk("fl+fire cnt0", {28'd0, cnt0}, 32'd4);
      chk("fl+fire v0", {31'd0, out0_valid}, 32'd0);

      // Counter wrap: 17 transfers from zero on a 4-bit counter
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
      for (int i = 0; i < 17; i++) begin
         in_data = 32'h100 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      tick(); #1;
      chk("wrap cnt0", {28'd0, cnt0}, 32'd1);

      // Reset in the middle of a stall
      out0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hCAFE;
      tick(); in_sel = 1'b1; in_data = 32'hBEEF;
      tick(); in_valid = 1'b0; rst_n = 1'b0; #1;
      chk("mr ready", {31'd0, in_ready}, 32'd0);
      tick(); rst_n = 1'b1; #1;
      chk("mr v0", {31'd0, out0_valid}, 32'd0);
      chk("mr v1", {31'd0, out1_valid}, 32'd0);
      chk("mr d0", out0_data, 32'd0);
      chk("mr d1", out1_data, 32'd0);
      chk("mr cnt0", {28'd0, cnt0}, 32'd0);

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         rst_n      = ($urandom_range(0, 199) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         in_valid   = ($urandom_range(0, 3) != 0);
         in_sel     = $urandom_range(0, 1);
         in_data    = $urandom;
         out0_ready = ($urandom_range(0, 2) != 0);
         out1_ready = ($urandom_range(0, 3) == 0);
         tick();
      end
      idle();
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
